// File: rtl/playfield_board.sv
// Playfield store for the falling-piece game: keeps the locked 10x20 grid,
// answers move-legality queries, locks pieces, clears full rows and raises
// game over. Also feeds per-cell occupancy/colour to the VGA pixel path.

package playfield_pkg;
  typedef enum logic [2:0] {
    BLK_NONE, BLK_I, BLK_O, BLK_T, BLK_S, BLK_Z, BLK_J, BLK_L
  } block_color;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOCK, ST_SCAN, ST_SHIFT, ST_SPAWN_CHK
  } board_state_e;
endpackage

module playfield_board
  import playfield_pkg::*;
#(
  parameter int COLS      = 10,
  parameter int ROWS      = 20,
  parameter int MAX_LINES = 9999
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         get_new_block,
  input  logic [19:0]  x_block,
  input  logic [19:0]  y_block,
  input  block_color   block,
  input  logic [19:0]  x_move_left,
  input  logic [19:0]  y_move_left,
  input  logic [19:0]  x_move_right,
  input  logic [19:0]  y_move_right,
  input  logic [19:0]  x_move_down,
  input  logic [19:0]  y_move_down,
  input  logic [19:0]  x_rotate_left,
  input  logic [19:0]  y_rotate_left,
  input  logic [19:0]  x_rotate_right,
  input  logic [19:0]  y_rotate_right,
  input  logic         play_area,
  input  logic [4:0]   x_coord,
  input  logic [4:0]   y_coord,
  output logic [4:0]   can_move,
  output logic         BOARD_BUSY,
  output logic         cell_occupied,
  output block_color   cell_color,
  output logic [13:0]  lines_cleared,
  output logic         game_over,
  output board_state_e fsm_state
);

  localparam int              XW       = $clog2(COLS);
  localparam int              YW       = $clog2(ROWS);
  localparam logic [4:0]      COLS_C   = 5'(COLS);
  localparam logic [4:0]      ROWS_C   = 5'(ROWS);
  localparam logic [13:0]     MAX_C    = 14'(MAX_LINES);
  localparam logic [YW-1:0]   LAST_ROW = YW'(ROWS - 1);

  // Handshake: get_new_block is a one-cycle request that is only accepted in
  // IDLE with game_over low; BOARD_BUSY is the "not ready" indication and stays
  // high from the cycle after acceptance until the board is back in IDLE.

  board_state_e   state;
  logic [COLS-1:0] occ  [ROWS];
  block_color      colr [ROWS][COLS];
  logic [19:0]     cap_x, cap_y;
  block_color      cap_blk;
  logic [YW-1:0]   row, k;
  logic            accept;

  assign accept     = (state == ST_IDLE) && get_new_block && !game_over;
  assign BOARD_BUSY = (state != ST_IDLE);
  assign fsm_state  = state;

  // Occupancy of a locked cell; anything off the board reads as empty.
  function automatic logic cell_at(input logic [4:0] x, input logic [4:0] y);
    cell_at = 1'b0;
    if (x < COLS_C && y < ROWS_C) cell_at = occ[y[YW-1:0]][x[XW-1:0]];
  endfunction

  // A candidate is legal only if every cell is on the board and free.
  // Coordinates that underflowed to 31 fall out of range and fail here.
  function automatic logic legal(input logic [19:0] xs, input logic [19:0] ys);
    logic [4:0] cx, cy;
    legal = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cx = xs[15-5*i +: 5];
      cy = ys[15-5*i +: 5];
      if (cx >= COLS_C || cy >= ROWS_C || cell_at(cx, cy)) legal = 1'b0;
    end
  endfunction

  // True if any on-board cell of the piece lands on a locked cell.
  function automatic logic overlaps(input logic [19:0] xs, input logic [19:0] ys);
    overlaps = 1'b0;
    for (int i = 0; i < 4; i++)
      if (cell_at(xs[15-5*i +: 5], ys[15-5*i +: 5])) overlaps = 1'b1;
  endfunction

  // Pixel lookup: locked colour wins over the active piece.
  always_comb begin
    logic       active_hit;
    logic       grid_hit;
    block_color grid_col;
    active_hit = 1'b0;
    for (int i = 0; i < 4; i++)
      if (x_block[15-5*i +: 5] == x_coord && y_block[15-5*i +: 5] == y_coord)
        active_hit = 1'b1;
    grid_hit = cell_at(x_coord, y_coord);
    grid_col = BLK_NONE;
    if (grid_hit) grid_col = colr[y_coord[YW-1:0]][x_coord[XW-1:0]];
    cell_occupied = 1'b0;
    cell_color    = BLK_NONE;
    if (play_area) begin
      cell_occupied = grid_hit | active_hit;
      if (grid_hit)        cell_color = grid_col;
      else if (active_hit) cell_color = block;
    end
  end

  // Board FSM: lock, scan/shift full rows, spawn check; also registers can_move.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= ST_IDLE;
      can_move      <= '0;
      lines_cleared <= '0;
      game_over     <= 1'b0;
      cap_x         <= '0;
      cap_y         <= '0;
      cap_blk       <= BLK_NONE;
      row           <= '0;
      k             <= '0;
      for (int r = 0; r < ROWS; r++) begin
        occ[r] <= '0;
        for (int c = 0; c < COLS; c++) colr[r][c] <= BLK_NONE;
      end
    end else begin
      if (state != ST_IDLE || game_over || accept)
        can_move <= '0;
      else
        can_move <= {legal(x_move_left,    y_move_left),
                     legal(x_move_right,   y_move_right),
                     legal(x_rotate_right, y_rotate_right),
                     legal(x_rotate_left,  y_rotate_left),
                     legal(x_move_down,    y_move_down)};

      case (state)
        ST_IDLE: begin
          if (accept) begin
            cap_x   <= x_block;
            cap_y   <= y_block;
            cap_blk <= block;
            state   <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          for (int i = 0; i < 4; i++) begin
            if (cap_x[15-5*i +: 5] < COLS_C && cap_y[15-5*i +: 5] < ROWS_C) begin
              occ[cap_y[15-5*i +: YW]][cap_x[15-5*i +: XW]]  <= 1'b1;
              colr[cap_y[15-5*i +: YW]][cap_x[15-5*i +: XW]] <= cap_blk;
            end
          end
          row   <= LAST_ROW;
          state <= ST_SCAN;
        end
        ST_SCAN: begin
          if (&occ[row]) begin
            k     <= row;
            state <= ST_SHIFT;
          end else if (row == '0) begin
            state <= ST_SPAWN_CHK;
          end else begin
            row <= row - 1'b1;
          end
        end
        ST_SHIFT: begin
          if (k == '0) begin
            occ[0] <= '0;
            for (int c = 0; c < COLS; c++) colr[0][c] <= BLK_NONE;
            if (lines_cleared < MAX_C) lines_cleared <= lines_cleared + 14'd1;
            state <= ST_SCAN;
          end else begin
            occ[k] <= occ[k - 1'b1];
            for (int c = 0; c < COLS; c++) colr[k][c] <= colr[k - 1'b1][c];
            k <= k - 1'b1;
          end
        end
        ST_SPAWN_CHK: begin
          if (overlaps(x_block, y_block)) game_over <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_playfield_board.sv
// Directed bench for playfield_board: legality, lock timing, row clear,
// game over and reset during a shift.

module tb_playfield_board;
  import playfield_pkg::*;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         get_new_block;
  logic [19:0]  x_block, y_block;
  block_color   block;
  logic [19:0]  x_move_left, y_move_left, x_move_right, y_move_right;
  logic [19:0]  x_move_down, y_move_down, x_rotate_left, y_rotate_left;
  logic [19:0]  x_rotate_right, y_rotate_right;
  logic         play_area;
  logic [4:0]   x_coord, y_coord;
  logic [4:0]   can_move;
  logic         BOARD_BUSY;
  logic         cell_occupied;
  block_color   cell_color;
  logic [13:0]  lines_cleared;
  logic         game_over;
  board_state_e fsm_state;

  int checks = 0;
  int errors = 0;
  int busy_n, cm_n;

  localparam logic [19:0] OFF = 20'hFFFFF;  // every cell at 31: off the board

  playfield_board dut (
    .Clk(Clk), .Reset(Reset), .get_new_block(get_new_block),
    .x_block(x_block), .y_block(y_block), .block(block),
    .x_move_left(x_move_left), .y_move_left(y_move_left),
    .x_move_right(x_move_right), .y_move_right(y_move_right),
    .x_move_down(x_move_down), .y_move_down(y_move_down),
    .x_rotate_left(x_rotate_left), .y_rotate_left(y_rotate_left),
    .x_rotate_right(x_rotate_right), .y_rotate_right(y_rotate_right),
    .play_area(play_area), .x_coord(x_coord), .y_coord(y_coord),
    .can_move(can_move), .BOARD_BUSY(BOARD_BUSY),
    .cell_occupied(cell_occupied), .cell_color(cell_color),
    .lines_cleared(lines_cleared), .game_over(game_over),
    .fsm_state(fsm_state)
  );

  // clock / watchdog
  always #10 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] pk(input logic [4:0] a, input logic [4:0] b,
                                     input logic [4:0] c, input logic [4:0] d);
    return {a, b, c, d};
  endfunction

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic check_cell(input string tag, input int x, input int y,
                            input logic exp_occ, input block_color exp_col);
    @(negedge Clk);
    play_area = 1'b1;
    x_coord   = 5'(x);
    y_coord   = 5'(y);
    #2;
    check({tag, "_occ"}, cell_occupied, exp_occ);
    check({tag, "_col"}, cell_color, exp_col);
    play_area = 1'b0;
  endtask

  // Pulse get_new_block with piece p*, then present spawn piece s* and count
  // busy cycles and cycles where can_move was nonzero while busy.
  task automatic lock_piece(input logic [19:0] px, input logic [19:0] py, input block_color pb,
                            input logic [19:0] sx, input logic [19:0] sy,
                            output int busy, output int cm_hits);
    @(negedge Clk);
    x_block = px; y_block = py; block = pb; get_new_block = 1'b1;
    @(posedge Clk); #1;
    get_new_block = 1'b0; x_block = sx; y_block = sy; block = BLK_NONE;
    busy = 0; cm_hits = 0;
    while (BOARD_BUSY && busy < 500) begin
      busy++;
      if (can_move != 5'd0) cm_hits++;
      @(posedge Clk); #1;
    end
  endtask

  task automatic set_j_candidates();
    // J piece at x={0,0,1,2} y={0,1,1,1}
    x_move_left    = pk(31, 31, 0, 1); y_move_left    = pk(0, 1, 1, 1);
    x_move_right   = pk(1, 1, 2, 3);   y_move_right   = pk(0, 1, 1, 1);
    x_move_down    = pk(0, 0, 1, 2);   y_move_down    = pk(1, 2, 2, 2);
    x_rotate_left  = pk(31, 0, 0, 0);  y_rotate_left  = pk(0, 0, 1, 2);
    x_rotate_right = pk(1, 1, 1, 1);   y_rotate_right = pk(17, 18, 19, 20);
  endtask

  initial begin
    Reset = 1'b1; get_new_block = 1'b0; play_area = 1'b0;
    x_coord = '0; y_coord = '0; block = BLK_T;
    // T piece x={4,5,5,6} y={1,0,1,1}
    x_block = pk(4, 5, 5, 6); y_block = pk(1, 0, 1, 1);
    x_move_left    = pk(3, 4, 4, 5);   y_move_left    = pk(1, 0, 1, 1);
    x_move_right   = pk(5, 6, 6, 7);   y_move_right   = pk(1, 0, 1, 1);
    x_move_down    = pk(4, 5, 5, 6);   y_move_down    = pk(2, 1, 2, 2);
    x_rotate_left  = pk(5, 5, 5, 4);   y_rotate_left  = pk(31, 0, 1, 0);
    x_rotate_right = pk(5, 5, 5, 6);   y_rotate_right = pk(0, 1, 2, 1);

    // 1. reset state and T-piece legality
    tick(); tick();
    check("rst_can_move", can_move, 5'd0);
    check("rst_busy", BOARD_BUSY, 1'b0);
    check("rst_lines", lines_cleared, 14'd0);
    check("rst_game_over", game_over, 1'b0);
    check("rst_state", fsm_state, ST_IDLE);
    @(negedge Clk); Reset = 1'b0;
    tick();
    check("t1_can_move", can_move, 5'b11101);
    check("t1_busy", BOARD_BUSY, 1'b0);
    check_cell("t1_active", 5, 0, 1'b1, BLK_T);
    @(negedge Clk); play_area = 1'b0; x_coord = 5'd5; y_coord = 5'd0; #2;
    check("t1_outside_occ", cell_occupied, 1'b0);
    check("t1_outside_col", cell_color, BLK_NONE);

    // 2. wrap-around and boundary candidates
    @(negedge Clk);
    x_block = OFF; y_block = OFF;
    set_j_candidates();
    #1;
    check("t2_latency", can_move, 5'b11101);
    tick();
    check("t2_can_move", can_move, 5'b01001);
    @(negedge Clk); x_move_right = pk(7, 8, 9, 10); y_move_right = pk(0, 0, 0, 0);
    tick();
    check("t2_right_x10", can_move, 5'b00001);
    @(negedge Clk); set_j_candidates();
    tick();
    check("t2_restore", can_move, 5'b01001);

    // 3. lock I piece on row 19
    lock_piece(pk(3, 4, 5, 6), pk(19, 19, 19, 19), BLK_I, OFF, OFF, busy_n, cm_n);
    check("t3_busy_cycles", busy_n, 22);
    check("t3_can_move_busy", cm_n, 0);
    check_cell("t3_c3", 3, 19, 1'b1, BLK_I);
    check_cell("t3_c6", 6, 19, 1'b1, BLK_I);
    check_cell("t3_c2", 2, 19, 1'b0, BLK_NONE);
    check_cell("t3_c7", 7, 19, 1'b0, BLK_NONE);
    check("t3_can_move_after", can_move, 5'b01001);

    // 4. fill row 19 except col 9, plus (0,18), then complete it
    lock_piece(pk(0, 1, 2, 0), pk(19, 19, 19, 18), BLK_L, OFF, OFF, busy_n, cm_n);
    check("t4_busy_a", busy_n, 22);
    lock_piece(pk(7, 8, 31, 31), pk(19, 19, 31, 31), BLK_O, OFF, OFF, busy_n, cm_n);
    check("t4_busy_b", busy_n, 22);
    check("t4_lines_before", lines_cleared, 14'd0);
    lock_piece(pk(9, 31, 31, 31), pk(19, 31, 31, 31), BLK_S, OFF, OFF, busy_n, cm_n);
    check("t4_busy_clear", busy_n, 43);
    check("t4_can_move_busy", cm_n, 0);
    check("t4_lines", lines_cleared, 14'd1);
    check_cell("t4_c0r19", 0, 19, 1'b1, BLK_L);
    check_cell("t4_c1r19", 1, 19, 1'b0, BLK_NONE);
    check_cell("t4_c5r19", 5, 19, 1'b0, BLK_NONE);
    check_cell("t4_c9r19", 9, 19, 1'b0, BLK_NONE);
    check_cell("t4_c0r18", 0, 18, 1'b0, BLK_NONE);

    // 5. block the spawn area -> game over
    check("t5_go_before", game_over, 1'b0);
    lock_piece(pk(5, 31, 31, 31), pk(1, 31, 31, 31), BLK_Z,
               pk(4, 5, 5, 6), pk(1, 0, 1, 1), busy_n, cm_n);
    check("t5_busy", busy_n, 22);
    check("t5_game_over", game_over, 1'b1);
    tick();
    check("t5_can_move", can_move, 5'd0);
    @(negedge Clk);
    x_block = pk(0, 31, 31, 31); y_block = pk(0, 31, 31, 31); block = BLK_J;
    get_new_block = 1'b1;
    tick();
    get_new_block = 1'b0; x_block = OFF; y_block = OFF;
    check("t5_ignored_busy", BOARD_BUSY, 1'b0);
    tick(); tick();
    check_cell("t5_c0r0", 0, 0, 1'b0, BLK_NONE);
    check("t5_go_sticky", game_over, 1'b1);

    // 6. reset out of game over, clear one row, then reset mid-SHIFT
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk); Reset = 1'b0;
    check("t6_go_cleared", game_over, 1'b0);
    lock_piece(pk(0, 1, 2, 3), pk(19, 19, 19, 19), BLK_I, OFF, OFF, busy_n, cm_n);
    lock_piece(pk(4, 5, 6, 7), pk(19, 19, 19, 19), BLK_I, OFF, OFF, busy_n, cm_n);
    lock_piece(pk(8, 9, 31, 31), pk(19, 19, 31, 31), BLK_O, OFF, OFF, busy_n, cm_n);
    check("t6_busy_clear", busy_n, 43);
    check("t6_lines", lines_cleared, 14'd1);
    lock_piece(pk(0, 1, 2, 3), pk(19, 19, 19, 19), BLK_I, OFF, OFF, busy_n, cm_n);
    lock_piece(pk(4, 5, 6, 7), pk(19, 19, 19, 19), BLK_I, OFF, OFF, busy_n, cm_n);
    @(negedge Clk);
    x_block = pk(8, 9, 31, 31); y_block = pk(19, 19, 31, 31); block = BLK_O;
    get_new_block = 1'b1;
    tick();
    get_new_block = 1'b0; x_block = OFF; y_block = OFF;
    check("t6_state_lock", fsm_state, ST_LOCK);
    tick();
    check("t6_state_scan", fsm_state, ST_SCAN);
    tick();
    check("t6_state_shift", fsm_state, ST_SHIFT);
    tick();
    @(negedge Clk); Reset = 1'b1;
    tick();
    check("t6_rst_busy", BOARD_BUSY, 1'b0);
    check("t6_rst_lines", lines_cleared, 14'd0);
    check("t6_rst_state", fsm_state, ST_IDLE);
    check("t6_rst_can_move", can_move, 5'd0);
    @(negedge Clk); Reset = 1'b0;
    check_cell("t6_c0r19", 0, 19, 1'b0, BLK_NONE);
    check_cell("t6_c4r19", 4, 19, 1'b0, BLK_NONE);
    check_cell("t6_c3r18", 3, 18, 1'b0, BLK_NONE);
    check("t6_can_move_after", can_move, 5'b01001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
